// File: rtl/rv32i_single_cycle_core_pkg.sv
// Shared RV32I encodings, ALU operation and write-back select enums for the single-cycle core.
package rv32i_single_cycle_core_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC4
    } wb_sel_e;

    // alt selects SUB/SRA; callers must only raise it where the encoding allows.
    function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD_SUB: return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     return ALU_SLL;
            F3_SLT:     return ALU_SLT;
            F3_SLTU:    return ALU_SLTU;
            F3_XOR:     return ALU_XOR;
            F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
            F3_OR:      return ALU_OR;
            default:    return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// 32x32 register file: two combinational read ports, one clocked write port, x0 hardwired to zero.
module rv32i_regfile #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        wr_en,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data
);

    // x0 has no storage at all, so it can never hold a stale value.
    logic [31:0] regs_q [1:NUM_REGS-1];
    logic [31:0] regs_d [1:NUM_REGS-1];

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            always_comb begin
                regs_d[gi] = regs_q[gi];
                if (wr_en && (rd_addr == 5'(gi))) begin
                    regs_d[gi] = rd_data;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs_q[rs1_addr];
        rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs_q[rs2_addr];
    end

endmodule

// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core: decode, ALU, branch and PC logic around rv32i_regfile.
// Optional macro CPU_HALT_ON_EBREAK_EN makes EBREAK freeze the core until reset.
module rv32i_single_cycle_core
    import rv32i_single_cycle_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] mem_rd_data,
    output logic        mem_wr_sig,
    output logic [31:0] mem_wr_data,
    output logic [31:0] mem_addr,
    output logic [31:0] new_pc
);

    logic [31:0] pc_q, pc_d;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'd0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    logic [31:0] rs1_val, rs2_val;
    logic        rf_wr_en;
    logic [31:0] wb_data;

    rv32i_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .wr_en    (rf_wr_en),
        .rd_addr  (rd),
        .rd_data  (wb_data)
    );

    alu_op_e     alu_op;
    wb_sel_e     wb_sel;
    logic [31:0] imm;
    logic        alu_src_imm, alu_a_pc;
    logic        reg_we, mem_we;
    logic        is_branch, is_jal, is_jalr, is_ebreak;

    always_comb begin
        alu_op      = ALU_ADD;
        wb_sel      = WB_ALU;
        imm         = imm_i;
        alu_src_imm = 1'b0;
        alu_a_pc    = 1'b0;
        reg_we      = 1'b0;
        mem_we      = 1'b0;
        is_branch   = 1'b0;
        is_jal      = 1'b0;
        is_jalr     = 1'b0;
        is_ebreak   = 1'b0;
        case (opcode)
            OP_LUI: begin
                alu_op      = ALU_PASS_B;
                imm         = imm_u;
                alu_src_imm = 1'b1;
                reg_we      = 1'b1;
            end
            OP_AUIPC: begin
                imm         = imm_u;
                alu_src_imm = 1'b1;
                alu_a_pc    = 1'b1;
                reg_we      = 1'b1;
            end
            OP_JAL: begin
                imm    = imm_j;
                is_jal = 1'b1;
                wb_sel = WB_PC4;
                reg_we = 1'b1;
            end
            OP_JALR: begin
                if (funct3 == F3_JALR) begin
                    alu_src_imm = 1'b1;
                    is_jalr     = 1'b1;
                    wb_sel      = WB_PC4;
                    reg_we      = 1'b1;
                end
            end
            OP_BRANCH: begin
                imm       = imm_b;
                is_branch = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OP_LOAD: begin
                if (funct3 == F3_LW) begin
                    alu_src_imm = 1'b1;
                    wb_sel      = WB_MEM;
                    reg_we      = 1'b1;
                end
            end
            OP_STORE: begin
                imm         = imm_s;
                alu_src_imm = 1'b1;
                mem_we      = (funct3 == F3_SW);
            end
            OP_IMM: begin
                alu_src_imm = 1'b1;
                alu_op      = alu_op_from_f3(funct3, funct7[5] && (funct3 == F3_SRL_SRA));
                // Shift-immediates carry funct7 in the immediate field; reject bad encodings.
                if (funct3 == F3_SLL) begin
                    reg_we = (funct7 == F7_BASE);
                end else if (funct3 == F3_SRL_SRA) begin
                    reg_we = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                end else begin
                    reg_we = 1'b1;
                end
            end
            OP_REG: begin
                alu_op = alu_op_from_f3(funct3, funct7[5]);
                reg_we = (funct7 == F7_BASE) ||
                         ((funct7 == F7_ALT) &&
                          ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)));
            end
            OP_SYSTEM: begin
`ifdef CPU_HALT_ON_EBREAK_EN
                is_ebreak = (instruction == INSN_EBREAK);
`endif
            end
            default: begin
            end
        endcase
    end

    logic [31:0] alu_a, alu_b, alu_result;
    logic [4:0]  shamt;

    assign alu_a = alu_a_pc ? pc_q : rs1_val;
    assign alu_b = alu_src_imm ? imm : rs2_val;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            ALU_ADD:    alu_result = alu_a + alu_b;
            ALU_SUB:    alu_result = alu_a - alu_b;
            ALU_SLL:    alu_result = alu_a << shamt;
            ALU_SLT:    alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU:   alu_result = {31'd0, alu_a < alu_b};
            ALU_XOR:    alu_result = alu_a ^ alu_b;
            ALU_SRL:    alu_result = alu_a >> shamt;
            ALU_SRA:    alu_result = $unsigned($signed(alu_a) >>> shamt);
            ALU_OR:     alu_result = alu_a | alu_b;
            ALU_AND:    alu_result = alu_a & alu_b;
            ALU_PASS_B: alu_result = alu_b;
            default:    alu_result = 32'd0;
        endcase
    end

    logic branch_cond;

    always_comb begin
        branch_cond = 1'b0;
        case (funct3)
            F3_BEQ:  branch_cond = (rs1_val == rs2_val);
            F3_BNE:  branch_cond = (rs1_val != rs2_val);
            F3_BLT:  branch_cond = ($signed(rs1_val) < $signed(rs2_val));
            F3_BGE:  branch_cond = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: branch_cond = (rs1_val < rs2_val);
            F3_BGEU: branch_cond = (rs1_val >= rs2_val);
            default: branch_cond = 1'b0;
        endcase
    end

    // freeze covers both the EBREAK cycle itself and every cycle after it.
    logic freeze;

`ifdef CPU_HALT_ON_EBREAK_EN
    logic halted_q, halted_d;

    assign halted_d = halted_q | is_ebreak;
    assign freeze   = halted_q | is_ebreak;

    always_ff @(posedge clk) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
`else
    assign freeze = is_ebreak;
`endif

    logic [31:0] pc_plus4, pc_target;

    assign pc_plus4  = pc_q + 32'd4;
    assign pc_target = pc_q + imm;

    always_comb begin
        pc_d = pc_plus4;
        if (freeze) begin
            pc_d = pc_q;
        end else if (is_jalr) begin
            pc_d = {alu_result[31:1], 1'b0};
        end else if (is_jal || (is_branch && branch_cond)) begin
            pc_d = pc_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_comb begin
        case (wb_sel)
            WB_MEM:  wb_data = mem_rd_data;
            WB_PC4:  wb_data = pc_plus4;
            default: wb_data = alu_result;
        endcase
    end

    assign rf_wr_en    = reg_we && !reset && !freeze;
    assign mem_wr_sig  = mem_we && !reset && !freeze;
    assign mem_wr_data = rs2_val;
    assign mem_addr    = alu_result;
    assign new_pc      = pc_q;

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Randomized self-checking bench: an instruction-set model predicts PC, store traffic and register state.
module tb_rv32i_single_cycle_core;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] mem_rd_data;
    logic        mem_wr_sig;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_addr;
    logic [31:0] new_pc;

    rv32i_single_cycle_core dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .mem_rd_data (mem_rd_data),
        .mem_wr_sig  (mem_wr_sig),
        .mem_wr_data (mem_wr_data),
        .mem_addr    (mem_addr),
        .new_pc      (new_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment RAM, word addressed with 256-word aliasing.
    logic [31:0] ram [256];
    assign mem_rd_data = ram[mem_addr[9:2]];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
        end else if (mem_wr_sig) begin
            ram[mem_addr[9:2]] <= mem_wr_data;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural reference state.
    logic [31:0] m_pc;
    logic [31:0] m_x   [32];
    logic [31:0] m_mem [256];
    logic        m_halted;

    logic        last_we;
    logic [31:0] last_addr, last_data;

    task automatic model_reset();
        m_pc     = 32'h0000_0000;
        m_halted = 1'b0;
        for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
        for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;
    endtask

    task automatic model_exec(input logic [31:0] ins, output logic e_we,
                              output logic [31:0] e_addr, output logic [31:0] e_data);
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] a, b, opb, immi, imms, immb, immu, immj, val, nxt, ea;
        logic        wr, alt, taken;
        op   = ins[6:0];
        rd   = ins[11:7];
        f3   = ins[14:12];
        a    = m_x[ins[19:15]];
        b    = m_x[ins[24:20]];
        alt  = (ins[31:25] == 7'h20);
        immi = {{20{ins[31]}}, ins[31:20]};
        imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        immu = {ins[31:12], 12'd0};
        immj = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        e_we = 1'b0; e_addr = 32'd0; e_data = 32'd0;
        wr = 1'b0; val = 32'd0; nxt = m_pc + 32'd4; taken = 1'b0;
        if (m_halted) begin
            nxt = m_pc;
        end else begin
            case (op)
                7'h37: begin wr = 1'b1; val = immu; end
                7'h17: begin wr = 1'b1; val = m_pc + immu; end
                7'h6F: begin wr = 1'b1; val = m_pc + 32'd4; nxt = m_pc + immj; end
                7'h67: if (f3 == 3'd0) begin
                    wr = 1'b1; val = m_pc + 32'd4; nxt = (a + immi) & ~32'd1;
                end
                7'h63: begin
                    case (f3)
                        3'd0: taken = (a == b);
                        3'd1: taken = (a != b);
                        3'd4: taken = ($signed(a) < $signed(b));
                        3'd5: taken = ($signed(a) >= $signed(b));
                        3'd6: taken = (a < b);
                        3'd7: taken = (a >= b);
                        default: taken = 1'b0;
                    endcase
                    if (taken) nxt = m_pc + immb;
                end
                7'h03: if (f3 == 3'd2) begin
                    ea = a + immi; wr = 1'b1; val = m_mem[ea[9:2]];
                end
                7'h23: if (f3 == 3'd2) begin
                    ea = a + imms; e_we = 1'b1; e_addr = ea; e_data = b;
                    m_mem[ea[9:2]] = b;
                end
                7'h13, 7'h33: begin
                    wr  = 1'b1;
                    opb = (op == 7'h13) ? immi : b;
                    case (f3)
                        3'd0: val = (op == 7'h33 && alt) ? a - opb : a + opb;
                        3'd1: val = a << opb[4:0];
                        3'd2: val = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
                        3'd3: val = (a < opb) ? 32'd1 : 32'd0;
                        3'd4: val = a ^ opb;
                        3'd5: val = alt ? $unsigned($signed(a) >>> opb[4:0]) : a >> opb[4:0];
                        3'd6: val = a | opb;
                        default: val = a & opb;
                    endcase
                end
                7'h73: begin
`ifdef CPU_HALT_ON_EBREAK_EN
                    if (ins == 32'h0010_0073) begin
                        m_halted = 1'b1; nxt = m_pc;
                    end
`endif
                end
                default: ;
            endcase
        end
        if (wr && rd != 5'd0) m_x[rd] = val;
        m_pc = nxt;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
    endfunction

    localparam logic [31:0] NOP = 32'h0000_0013;

    task automatic run_instr(input logic [31:0] ins);
        logic        e_we;
        logic [31:0] e_addr, e_data, old_pc;
        old_pc      = m_pc;
        instruction = ins;
        #1;
        last_we   = mem_wr_sig;
        last_addr = mem_addr;
        last_data = mem_wr_data;
        model_exec(ins, e_we, e_addr, e_data);
        check("wr_sig", {31'd0, mem_wr_sig}, {31'd0, e_we});
        if (e_we) begin
            check("mem_addr", mem_addr, e_addr);
            check("wr_data", mem_wr_data, e_data);
        end
        @(posedge clk);
        #1;
        check("pc", new_pc, m_pc);
        $display("pc=%h ins=%h we=%0d addr=%h wdata=%h next=%h",
                 old_pc, ins, last_we, last_addr, last_data, new_pc);
    endtask

    // Reset is held while a store is presented, so any write leak is visible.
    task automatic do_reset(input int cycles);
        reset       = 1'b1;
        instruction = enc_s(32'd0, 5'd1, 5'd0);
        for (int i = 0; i < cycles; i++) begin
            #1;
            check("rst_wr_sig", {31'd0, mem_wr_sig}, 32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        model_reset();
        check("rst_pc", new_pc, 32'h0000_0000);
        $display("reset for %0d cycles, pc=%h", cycles, new_pc);
    endtask

    function automatic logic [4:0] rreg();
        return 5'($urandom_range(0, 15));
    endfunction

    function automatic logic [31:0] gen_rand();
        logic [31:0] r;
        logic [2:0]  f3;
        r = $urandom;
        case ($urandom_range(0, 13))
            0:  return enc_u(r[19:0], rreg(), 7'h37);
            1:  return enc_u(r[19:0], rreg(), 7'h17);
            2:  return enc_j({r[31:1], 1'b0}, rreg());
            3:  return enc_i(r, rreg(), 3'd0, rreg(), 7'h67);
            4: begin
                case ($urandom_range(0, 5))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd4;
                    3: f3 = 3'd5; 4: f3 = 3'd6; default: f3 = 3'd7;
                endcase
                return enc_b({r[31:1], 1'b0}, rreg(), rreg(), f3);
            end
            5:  return enc_i(r, rreg(), 3'd2, rreg(), 7'h03);
            6, 12, 13: return enc_s(r, rreg(), rreg());
            7: begin
                case ($urandom_range(0, 5))
                    0: f3 = 3'd0; 1: f3 = 3'd2; 2: f3 = 3'd3;
                    3: f3 = 3'd4; 4: f3 = 3'd6; default: f3 = 3'd7;
                endcase
                return enc_i(r, rreg(), f3, rreg(), 7'h13);
            end
            8: begin
                if (r[31]) return enc_i({20'd0, 7'h00, r[4:0]}, rreg(), 3'd1, rreg(), 7'h13);
                return enc_i({20'd0, r[30] ? 7'h20 : 7'h00, r[4:0]}, rreg(), 3'd5, rreg(), 7'h13);
            end
            9, 10: begin
                f3 = r[2:0];
                return enc_r((r[3] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00,
                             rreg(), rreg(), f3, rreg(), 7'h33);
            end
            default: begin
                case (r[1:0])
                    2'd0: return 32'h0000_0073;
                    2'd1: return 32'h0000_000F;
                    default: return {r[31:7], 7'h7F};
                endcase
            end
        endcase
    endfunction

    initial begin
        instruction = NOP;
        reset       = 1'b1;
        model_reset();
        do_reset(2);

        run_instr(NOP);
        check("pc_after_1", new_pc, 32'h4);
        run_instr(NOP);
        check("pc_after_2", new_pc, 32'h8);

        run_instr(enc_i(32'd5, 5'd0, 3'd0, 5'd1, 7'h13));
        run_instr(enc_i(-32'sd3, 5'd0, 3'd0, 5'd2, 7'h13));
        run_instr(enc_b(32'd12, 5'd1, 5'd1, 3'd0));
        check("beq_pc", new_pc, 32'h1C);
        run_instr(enc_b(32'd12, 5'd1, 5'd1, 3'd1));
        check("bne_pc", new_pc, 32'h20);

        run_instr(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33));
        run_instr(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33));
        run_instr(enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd5, 7'h33));
        run_instr(enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd6, 7'h33));
        run_instr(enc_s(32'd0, 5'd3, 5'd0));
        check("add_x3", last_data, 32'd2);
        run_instr(enc_s(32'd4, 5'd4, 5'd0));
        check("sub_x4", last_data, 32'd8);
        run_instr(enc_s(32'd16, 5'd5, 5'd0));
        check("slt_x5", last_data, 32'd1);
        run_instr(enc_s(32'd20, 5'd6, 5'd0));
        check("sltu_x6", last_data, 32'd0);

        run_instr(enc_s(32'd8, 5'd1, 5'd0));
        check("sw_we", {31'd0, last_we}, 32'd1);
        check("sw_addr", last_addr, 32'd8);
        check("sw_data", last_data, 32'd5);
        run_instr(enc_i(32'd8, 5'd0, 3'd2, 5'd7, 7'h03));
        check("lw_we", {31'd0, last_we}, 32'd0);
        run_instr(enc_s(32'd12, 5'd7, 5'd0));
        check("lw_x7", last_data, 32'd5);

        run_instr(enc_i(32'd7, 5'd0, 3'd0, 5'd0, 7'h13));
        run_instr(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd8, 7'h33));
        run_instr(enc_s(32'd24, 5'd8, 5'd0));
        check("x0_x8", last_data, 32'd0);
        run_instr(enc_u(20'h12345, 5'd9, 7'h37));
        run_instr(enc_s(32'd28, 5'd9, 5'd0));
        check("lui_x9", last_data, 32'h1234_5000);
        run_instr(enc_u(20'h80000, 5'd10, 7'h37));
        run_instr(enc_i({20'd0, 7'h20, 5'd4}, 5'd10, 3'd5, 5'd11, 7'h13));
        run_instr(enc_s(32'd32, 5'd11, 5'd0));
        check("srai_x11", last_data, 32'hF800_0000);

        run_instr(enc_j(32'h40 - m_pc, 5'd0));
        check("jump_to_40", new_pc, 32'h40);
        run_instr(enc_j(32'h20, 5'd1));
        check("jal_pc", new_pc, 32'h60);
        run_instr(enc_s(32'd36, 5'd1, 5'd0));
        check("jal_link", last_data, 32'h44);
        run_instr(enc_i(32'd5, 5'd1, 3'd0, 5'd0, 7'h67));
        check("jalr_pc", new_pc, 32'h48);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset(1);
            end
            run_instr(gen_rand());
        end

        for (int i = 1; i < 16; i++) begin
            run_instr(enc_s(32'(i * 4), 5'(i), 5'd0));
        end

        run_instr(32'h0010_0073);
        run_instr(enc_i(32'd1, 5'd0, 3'd0, 5'd1, 7'h13));
        run_instr(enc_s(32'd0, 5'd1, 5'd0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
